return_address_stack: RTL and testbench
=======================================

Name: return_address_stack

Overview:
- Speculative return address stack (RAS) in the fetch stage, directly downstream of the branch target buffer.
- It consumes the BTB's 2-bit branch type for the instruction being fetched. On a call (2'b01) it pushes the return address. On a return (2'b10) it supplies the predicted target and pops.
- The next-PC mux uses pred_ret_addr in place of the BTB target when type is return.
- Every fetch gets a pointer/count checkpoint. The backend hands that checkpoint back on a mispredict redirect, and the stack restores from it.

Parameters:
DEPTH, 16, number of 32-bit return-address entries (power of 2, >=2)
PTR_W, 4, log2(DEPTH); width of top-of-stack pointer

Ports:
clk  input  1  clock
resetn  input  1  reset
fetch_valid  input  1  a fetch-stage instruction is predicted this cycle
fetch_type  input  2  BTB type: 00 direct, 01 call, 10 return, 11 indirect
fetch_pc  input  32  PC of the branch/call instruction
pred_ret_addr  output  32  predicted return target (top entry), 0 when empty
pred_ret_valid  output  1  stack non-empty
ckpt_tos  output  PTR_W  current top pointer, carried with the fetched instruction
ckpt_cnt  output  PTR_W+1  current occupancy, carried with the fetched instruction
redirect_en  input  1  backend mispredict recovery
redirect_tos  input  PTR_W  checkpoint tos of the mispredicted instruction
redirect_cnt  input  PTR_W+1  checkpoint cnt of the mispredicted instruction
redirect_type  input  2  actual type of the mispredicted instruction
redirect_pc  input  32  PC of the mispredicted instruction

Behaviour:
- Reset (synchronous, active-low) is decided as: reset resetn, synchronous, active-low; clock clk.
- On reset: tos=0, cnt=0, all entries=0. Therefore pred_ret_valid=0, pred_ret_addr=0, ckpt_tos=0, ckpt_cnt=0.
- Reset mid-operation discards all state in that edge and overrides every other input.
- Storage is a circular array stack[0..DEPTH-1]; tos indexes the top valid entry.
- Outputs are combinational from registered state, with no input bypass:
  - pred_ret_valid = (cnt!=0).
  - pred_ret_addr = stack[tos] if cnt!=0, else 0.
  - ckpt_tos = tos; ckpt_cnt = cnt. Both are pre-update values, i.e. the state before this fetch's own push/pop.
- Fetch update at posedge clk, when fetch_valid=1 and redirect_en=0:
  - Call (01), push: tos <= tos+1 (mod DEPTH); stack[tos+1] <= fetch_pc+4; cnt <= min(cnt+1, DEPTH).
  - Call when full (cnt==DEPTH): overwrite the oldest entry via wrap; cnt stays DEPTH.
  - Return (10), pop: if cnt!=0, tos <= tos-1 (mod DEPTH) and cnt <= cnt-1.
  - Return when empty: no state change; the consumer sees pred_ret_valid=0 and falls back to the BTB target.
  - Types 00/11: no change.
- Redirect at posedge clk, when redirect_en=1. It has priority over fetch; the same-cycle fetch push/pop is dropped.
  - First restore tos=redirect_tos, cnt=redirect_cnt.
  - Then replay the mispredicted instruction's actual type against the restored state, with the same rules as fetch:
    - 01: push redirect_pc+4 at redirect_tos+1 and saturate cnt.
    - 10: pop if redirect_cnt!=0.
    - 00/11: restore only.
  - Entries are not rolled back. Entries overwritten on the wrong path stay corrupted; this is accepted prediction loss, not an error.
- Arithmetic:
  - Pointer arithmetic is modulo DEPTH (PTR_W-bit wrap).
  - cnt is PTR_W+1 bits and is never above DEPTH or below 0.
  - fetch_pc+4 wraps at 32 bits: 0xFFFFFFFC -> 0x00000000.
- Latency: a push or pop is visible on the outputs the cycle after its edge. Back-to-back call, call, return, return sequences are supported every cycle.

Test Plan:
1. Reset, then hold resetn=0 for 2 cycles and release -> pred_ret_valid=0, pred_ret_addr=0, ckpt_tos=0, ckpt_cnt=0.
2. Push/pop order:
   - Stimulus: calls at 0x1000, 0x2000, 0x3000 on consecutive cycles, then 3 returns.
   - Before each return, pred_ret_addr reads 0x3004, 0x2004, 0x1004 in that order.
   - Afterwards cnt=0 and pred_ret_valid=0.
3. Overflow:
   - Stimulus: 17 calls at PCs 0x100*k for k=1..17.
   - After the calls: cnt=16, pred_ret_addr=0x1104.
   - Then 16 returns yield 0x1104 down to 0x0204; entry 0x0104 is lost.
   - A 17th return leaves cnt=0 and does not change tos.
4. Return on empty:
   - Stimulus: after reset, fetch_type=10 for 3 cycles.
   - Response: tos stays 0, cnt stays 0, pred_ret_valid stays 0.
5. Recovery:
   - Stimulus: call at 0x4000; capture the checkpoint (tos=1, cnt=1) on the next fetch. Then do 2 wrong-path calls and 1 return. Then redirect_en with redirect_tos=1, redirect_cnt=1, redirect_type=01, redirect_pc=0x5000.
   - Response: cnt=2, pred_ret_addr=0x5004; the following return pops to 0x4004.
6. Same-cycle conflict:
   - Stimulus: redirect_en=1 (type=10, redirect_cnt=2, redirect_tos=3) together with fetch_valid=1, fetch_type=01.
   - Response: the fetch push is ignored; the result is tos=2, cnt=1.

Source files
------------

// File: rtl/return_address_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_address_stack
// Description : Speculative circular return-address stack for the fetch stage,
//               with per-fetch pointer/count checkpoints and redirect repair.
// Revision    : 1.0 - initial release
// ============================================================================
module return_address_stack #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             fetch_valid,
    input  logic [1:0]       fetch_type,
    input  logic [31:0]      fetch_pc,
    output logic [31:0]      pred_ret_addr,
    output logic             pred_ret_valid,
    output logic [PTR_W-1:0] ckpt_tos,
    output logic [PTR_W:0]   ckpt_cnt,
    input  logic             redirect_en,
    input  logic [PTR_W-1:0] redirect_tos,
    input  logic [PTR_W:0]   redirect_cnt,
    input  logic [1:0]       redirect_type,
    input  logic [31:0]      redirect_pc
);

    localparam logic [1:0]       C_TYPE_CALL = 2'b01;
    localparam logic [1:0]       C_TYPE_RET  = 2'b10;
    localparam logic [PTR_W:0]   C_CNT_MAX   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);

    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [31:0]      stack_q [DEPTH];

    logic             w_op_en;
    logic [1:0]       w_op_type;
    logic [31:0]      w_op_pc;
    logic [PTR_W-1:0] w_base_tos;
    logic [PTR_W:0]   w_base_cnt;
    logic             w_push_en;
    logic [PTR_W-1:0] w_push_idx;
    logic [31:0]      w_push_data;

    // A redirect restores the checkpoint and replays the real instruction on
    // top of it; any fetch in the same cycle is on the wrong path and dropped.
    always_comb begin
        w_op_en = fetch_valid | redirect_en;
        if (redirect_en) begin
            w_base_tos = redirect_tos;
            w_base_cnt = redirect_cnt;
            w_op_type  = redirect_type;
            w_op_pc    = redirect_pc;
        end else begin
            w_base_tos = tos_q;
            w_base_cnt = cnt_q;
            w_op_type  = fetch_type;
            w_op_pc    = fetch_pc;
        end
    end

    always_comb begin
        tos_d       = w_base_tos;
        cnt_d       = w_base_cnt;
        w_push_en   = 1'b0;
        w_push_idx  = w_base_tos + C_PTR_ONE;
        w_push_data = w_op_pc + 32'd4;
        if (w_op_en) begin
            case (w_op_type)
                C_TYPE_CALL: begin
                    // When full the pointer wrap overwrites the oldest entry.
                    tos_d     = w_push_idx;
                    w_push_en = 1'b1;
                    cnt_d     = (w_base_cnt >= C_CNT_MAX) ? C_CNT_MAX
                                                          : (w_base_cnt + C_CNT_ONE);
                end
                C_TYPE_RET: begin
                    if (w_base_cnt != '0) begin
                        tos_d = w_base_tos - C_PTR_ONE;
                        cnt_d = w_base_cnt - C_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tos_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            if (w_push_en) begin
                stack_q[w_push_idx] <= w_push_data;
            end
        end
    end

    assign pred_ret_valid = (cnt_q != '0);
    assign pred_ret_addr  = pred_ret_valid ? stack_q[tos_q] : 32'd0;
    assign ckpt_tos       = tos_q;
    assign ckpt_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_return_address_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_address_stack
// Description : Scoreboard bench for return_address_stack: directed scenarios
//               plus randomized fetch/redirect traffic against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_address_stack;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk;
    logic             resetn;
    logic             fetch_valid;
    logic [1:0]       fetch_type;
    logic [31:0]      fetch_pc;
    logic [31:0]      pred_ret_addr;
    logic             pred_ret_valid;
    logic [PTR_W-1:0] ckpt_tos;
    logic [PTR_W:0]   ckpt_cnt;
    logic             redirect_en;
    logic [PTR_W-1:0] redirect_tos;
    logic [PTR_W:0]   redirect_cnt;
    logic [1:0]       redirect_type;
    logic [31:0]      redirect_pc;

    return_address_stack #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .fetch_valid   (fetch_valid),
        .fetch_type    (fetch_type),
        .fetch_pc      (fetch_pc),
        .pred_ret_addr (pred_ret_addr),
        .pred_ret_valid(pred_ret_valid),
        .ckpt_tos      (ckpt_tos),
        .ckpt_cnt      (ckpt_cnt),
        .redirect_en   (redirect_en),
        .redirect_tos  (redirect_tos),
        .redirect_cnt  (redirect_cnt),
        .redirect_type (redirect_type),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] name;
        logic         v;
        logic [31:0]  a;
        logic [3:0]   t;
        logic [4:0]   c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain array plus integer pointer and occupancy.
    logic [31:0] m_stack [DEPTH];
    int          m_tos;
    int          m_cnt;
    int          hist_t[$];
    int          hist_c[$];

    function automatic void m_apply(input int bt, input int bc,
                                    input logic [1:0] ty, input logic [31:0] pc);
        m_tos = bt;
        m_cnt = bc;
        if (ty == 2'b01) begin
            m_tos = (bt + 1) % DEPTH;
            m_stack[m_tos] = pc + 32'd4;
            m_cnt = (bc + 1 > DEPTH) ? DEPTH : bc + 1;
        end else if (ty == 2'b10 && bc != 0) begin
            m_tos = (bt + DEPTH - 1) % DEPTH;
            m_cnt = bc - 1;
        end
    endfunction

    function automatic void chk(input logic [127:0] nm, input string fld,
                                input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %0s.%0s actual=%h required=%h", nm, fld, got, req);
        end
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk(mon_e.name, "valid", {31'd0, pred_ret_valid}, {31'd0, mon_e.v});
            chk(mon_e.name, "addr",  pred_ret_addr, mon_e.a);
            chk(mon_e.name, "tos",   {28'd0, ckpt_tos}, {28'd0, mon_e.t});
            chk(mon_e.name, "cnt",   {27'd0, ckpt_cnt}, {27'd0, mon_e.c});
        end
    end

    task automatic expect_dir(input logic [127:0] nm, input logic v, input logic [31:0] a,
                              input int t, input int c);
        exp_t e;
        e.name = nm;
        e.v    = v;
        e.a    = a;
        e.t    = 4'(t);
        e.c    = 5'(c);
        sb_q.push_back(e);
    endtask

    task automatic tick(input logic rn, input logic fv, input logic [1:0] ft,
                        input logic [31:0] fpc, input logic ren, input logic [3:0] rtos,
                        input logic [4:0] rcnt, input logic [1:0] rty, input logic [31:0] rpc);
        resetn        = rn;
        fetch_valid   = fv;
        fetch_type    = ft;
        fetch_pc      = fpc;
        redirect_en   = ren;
        redirect_tos  = rtos;
        redirect_cnt  = rcnt;
        redirect_type = rty;
        redirect_pc   = rpc;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < DEPTH; i++) m_stack[i] = 32'd0;
            m_tos = 0;
            m_cnt = 0;
        end else if (ren) begin
            m_apply(int'(rtos), int'(rcnt), rty, rpc);
        end else if (fv) begin
            m_apply(m_tos, m_cnt, ft, fpc);
        end
        #1;
        expect_dir("model", m_cnt != 0, (m_cnt != 0) ? m_stack[m_tos] : 32'd0, m_tos, m_cnt);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1, 2'b01, 32'h0000_9000, 1'b0, 4'd0, 5'd0, 2'b00, 32'd0);
        tick(1'b0, 1'b0, 2'b00, 32'd0, 1'b1, 4'd5, 5'd3, 2'b01, 32'h0000_1234);
        expect_dir("reset_hold", 1'b0, 32'd0, 0, 0);
        tick(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 4'd0, 5'd0, 2'b00, 32'd0);
        expect_dir("reset_rel", 1'b0, 32'd0, 0, 0);
    endtask

    task automatic fetch(input logic [1:0] ty, input logic [31:0] pc);
        tick(1'b1, 1'b1, ty, pc, 1'b0, 4'd0, 5'd0, 2'b00, 32'd0);
    endtask

    initial begin
        logic [1:0]  rty;
        logic [31:0] rpc;
        int          sel;
        int          hidx;

        resetn = 1'b0; fetch_valid = 1'b0; fetch_type = 2'b00; fetch_pc = 32'd0;
        redirect_en = 1'b0; redirect_tos = '0; redirect_cnt = '0;
        redirect_type = 2'b00; redirect_pc = 32'd0;
        m_tos = 0; m_cnt = 0;

        do_reset();

        // Push/pop ordering
        fetch(2'b01, 32'h1000);
        fetch(2'b01, 32'h2000);
        fetch(2'b01, 32'h3000);
        expect_dir("order_top", 1'b1, 32'h3004, 3, 3);
        fetch(2'b10, 32'h0);
        expect_dir("order_pop1", 1'b1, 32'h2004, 2, 2);
        fetch(2'b10, 32'h0);
        expect_dir("order_pop2", 1'b1, 32'h1004, 1, 1);
        fetch(2'b10, 32'h0);
        expect_dir("order_empty", 1'b0, 32'd0, 0, 0);

        // Overflow wrap
        do_reset();
        for (int k = 1; k <= 17; k++) fetch(2'b01, 32'(32'h100 * k));
        expect_dir("ovf_full", 1'b1, 32'h1104, 1, 16);
        for (int p = 1; p <= 16; p++) begin
            fetch(2'b10, 32'h0);
            if (p < 16) expect_dir("ovf_pop", 1'b1, 32'(32'h100 * (17 - p) + 4), (17 - p) % 16, 16 - p);
            else        expect_dir("ovf_drained", 1'b0, 32'd0, 1, 0);
        end
        fetch(2'b10, 32'h0);
        expect_dir("ovf_extra_ret", 1'b0, 32'd0, 1, 0);

        // Return on empty
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch(2'b10, 32'h0);
            expect_dir("empty_ret", 1'b0, 32'd0, 0, 0);
        end

        // Mispredict recovery
        do_reset();
        fetch(2'b01, 32'h4000);
        expect_dir("rec_ckpt", 1'b1, 32'h4004, 1, 1);
        fetch(2'b00, 32'h4010);
        fetch(2'b01, 32'h6000);
        fetch(2'b01, 32'h7000);
        fetch(2'b10, 32'h0);
        tick(1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 4'd1, 5'd1, 2'b01, 32'h5000);
        expect_dir("rec_redirect", 1'b1, 32'h5004, 2, 2);
        fetch(2'b10, 32'h0);
        expect_dir("rec_pop", 1'b1, 32'h4004, 1, 1);

        // Redirect beats a same-cycle fetch push
        tick(1'b1, 1'b1, 2'b01, 32'h8000, 1'b1, 4'd3, 5'd2, 2'b10, 32'h0);
        expect_dir("conflict", 1'b1, 32'h5004, 2, 1);

        // Return address wraps at 32 bits
        fetch(2'b01, 32'hFFFF_FFFC);
        expect_dir("pc_wrap", 1'b1, 32'h0000_0000, 3, 2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            hist_t.push_back(m_tos);
            hist_c.push_back(m_cnt);
            if (hist_t.size() > 8) begin
                void'(hist_t.pop_front());
                void'(hist_c.pop_front());
            end
            sel = int'($urandom_range(0, 99));
            rty = 2'($urandom_range(0, 3));
            rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if (sel < 2) begin
                tick(1'b0, 1'b1, rty, rpc, 1'($urandom), 4'($urandom), 5'($urandom_range(0, 16)), rty, rpc);
            end else if (sel < 14) begin
                hidx = int'($urandom_range(0, hist_t.size() - 1));
                if ($urandom_range(0, 3) != 0)
                    tick(1'b1, 1'($urandom), 2'($urandom), $urandom, 1'b1,
                         4'(hist_t[hidx]), 5'(hist_c[hidx]), rty, rpc);
                else
                    tick(1'b1, 1'($urandom), 2'($urandom), $urandom, 1'b1,
                         4'($urandom), 5'($urandom_range(0, 16)), rty, rpc);
            end else begin
                tick(1'b1, ($urandom_range(0, 7) != 0), rty, rpc, 1'b0,
                     4'($urandom), 5'($urandom), 2'($urandom), $urandom);
            end
        end

        fetch(2'b00, 32'h0);
        fetch(2'b00, 32'h0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
